// File: rtl/dmem_pkg.sv
// Shared types and default sizing for the MEM-stage data-port responder.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH  = 32;
  localparam int DMEM_ADDR_WIDTH  = 10;
  localparam int DMEM_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dmem_state_t;

  typedef struct packed {
    logic                       rw;
    logic [DMEM_DATA_WIDTH-1:0] addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, registered synchronous read.
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Contents are deliberately not reset; only the control path is.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// one-cycle rvalid pulse; mem_ready doubles as the pipeline stall source.
//
//   state   | meaning
//   DM_IDLE | ready; a request with mem_EN=1 is latched at the edge
//   DM_WAIT | counting wait states 0..WAIT_CYCLES-1
//   DM_RESP | rvalid=1 for one cycle, store already committed
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
  parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_EN,
  input  logic                  mem_RW,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  mem_ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp_err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmem_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  go_resp;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    go_resp = 1'b0;
    case (state_q)
      DM_IDLE: begin
        if (mem_EN) begin
          req_d.rw    = mem_RW;
          req_d.addr  = addr;
          req_d.wdata = wdata;
          cnt_d       = '0;
          if (WAIT_CYCLES == 0) begin
            state_d = DM_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = DM_WAIT;
          end
        end
      end
      DM_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          state_d = DM_RESP;
          go_resp = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // The array is touched on the edge entering RESP: stores commit there and
  // the registered read lands in the RESP cycle. Misaligned accesses never reach it.
  assign ram_en   = go_resp && !is_misaligned(req_d.addr[1:0]);
  assign ram_addr = req_d.addr[ADDR_WIDTH+1:2];

  dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i  (clk),
    .en_i   (ram_en),
    .we_i   (req_d.rw),
    .addr_i (ram_addr),
    .wdata_i(req_d.wdata),
    .rdata_o(ram_rdata)
  );

  assign mem_ready = (state_q == DM_IDLE);
  assign rvalid    = (state_q == DM_RESP);
  assign resp_err  = rvalid && is_misaligned(req_q.addr[1:0]);

  // rdata holds the last load result; store responses leave it alone.
  always_comb begin
    rdata = rdata_q;
    if (rvalid && !req_q.rw) begin
      rdata = resp_err ? '0 : ram_rdata;
    end
  end

  assign unused_addr_hi = ^req_q.addr[DATA_WIDTH-1:ADDR_WIDTH+2];

  a_mem_en_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(mem_EN))
    else $error("mem_EN is unknown");

endmodule
